// File: rtl/vc_alloc_requester_if.sv
// Bundle between one input port's VC buffers, the VC/switch allocator
// and the per-port requester front end.
interface vc_alloc_requester_if #(
    parameter int NUM_VCS  = 4,
    parameter int NUM_OUTS = 4
);
    localparam int RW = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

    logic [NUM_VCS-1:0]  head_valid;
    logic [RW-1:0]       head_route [NUM_VCS];
    logic [NUM_VCS-1:0]  flit_sent;
    logic [NUM_VCS-1:0]  flit_is_tail;
    logic [NUM_OUTS-1:0] requests [NUM_VCS];
    logic [NUM_OUTS-1:0] grants [NUM_VCS];
    logic [NUM_VCS-1:0]  vc_active;
    logic [RW-1:0]       vc_out_port [NUM_VCS];
    logic [NUM_VCS-1:0]  starve;
    logic                proto_err;

    modport master (
        output head_valid, head_route, flit_sent, flit_is_tail, grants,
        input  requests, vc_active, vc_out_port, starve, proto_err
    );

    modport slave (
        input  head_valid, head_route, flit_sent, flit_is_tail, grants,
        output requests, vc_active, vc_out_port, starve, proto_err
    );
endinterface

// File: rtl/vc_alloc_requester.sv
// Per-VC request/hold FSM feeding the VC/switch allocator; all outputs
// are registered, and starvation and protocol errors are flagged.
module vc_alloc_requester #(
    parameter int NUM_VCS  = 4,
    parameter int NUM_OUTS = 4,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input logic clk,
    input logic reset,
    vc_alloc_requester_if.slave bus
);
    localparam int RW = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state    [NUM_VCS];
    logic [NUM_OUTS-1:0] req_q    [NUM_VCS];
    logic [RW-1:0]       port_q   [NUM_VCS];
    logic [WAIT_W-1:0]   wait_q   [NUM_VCS];
    logic [WAIT_W-1:0]   wait_inc [NUM_VCS];
    logic [NUM_VCS-1:0]  active_q;
    logic [NUM_VCS-1:0]  starve_q;
    logic [NUM_VCS-1:0]  gnt_ok;
    logic [NUM_VCS-1:0]  err_vec;
    logic                err_q;

    function automatic logic [NUM_OUTS-1:0] onehot(input logic [RW-1:0] r);
        logic [NUM_OUTS-1:0] o;
        o    = '0;
        o[r] = 1'b1;
        return o;
    endfunction

    // req_q is one-hot while in REQ, so equality means exactly the asked-for bit
    always_comb begin
        gnt_ok  = '0;
        err_vec = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            wait_inc[v] = (wait_q[v] == WAIT_MAX) ? wait_q[v]
                                                  : wait_q[v] + 1'b1;
            gnt_ok[v] = (state[v] == REQ) && (bus.grants[v] == req_q[v]);
            if ((bus.grants[v] != '0) && !gnt_ok[v])
                err_vec[v] = 1'b1;
            if (bus.flit_sent[v] && (state[v] != ACTIVE))
                err_vec[v] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                state[v]  <= IDLE;
                req_q[v]  <= '0;
                port_q[v] <= '0;
                wait_q[v] <= '0;
            end
            active_q <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_q | (|err_vec);
            for (int v = 0; v < NUM_VCS; v++) begin
                unique case (state[v])
                    IDLE: begin
                        if (bus.head_valid[v]) begin
                            state[v]    <= REQ;
                            port_q[v]   <= bus.head_route[v];
                            req_q[v]    <= onehot(bus.head_route[v]);
                            wait_q[v]   <= '0;
                            starve_q[v] <= 1'b0;
                        end
                    end
                    REQ: begin
                        if (gnt_ok[v]) begin
                            state[v]    <= ACTIVE;
                            req_q[v]    <= '0;
                            active_q[v] <= 1'b1;
                            starve_q[v] <= 1'b0;
                        end else begin
                            wait_q[v]   <= wait_inc[v];
                            starve_q[v] <= (wait_inc[v] == WAIT_MAX);
                        end
                    end
                    ACTIVE: begin
                        // a head arriving with the tail waits one idle cycle
                        if (bus.flit_sent[v] && bus.flit_is_tail[v]) begin
                            state[v]    <= IDLE;
                            active_q[v] <= 1'b0;
                        end
                    end
                    default: begin
                        state[v]    <= IDLE;
                        req_q[v]    <= '0;
                        active_q[v] <= 1'b0;
                        starve_q[v] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.requests    = req_q;
    assign bus.vc_out_port = port_q;
    assign bus.vc_active   = active_q;
    assign bus.starve      = starve_q;
    assign bus.proto_err   = err_q;
endmodule

// File: tb/tb_vc_alloc_requester.sv
// Directed scenario bench for vc_alloc_requester (4 VCs, 4 outputs,
// MAX_WAIT 15).
module tb_vc_alloc_requester;
    localparam int NV = 4;
    localparam int NO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    vc_alloc_requester_if #(.NUM_VCS(NV), .NUM_OUTS(NO)) b ();

    vc_alloc_requester #(
        .NUM_VCS(NV), .NUM_OUTS(NO), .MAX_WAIT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] req_flat();
        logic [15:0] r;
        for (int v = 0; v < NV; v++) r[v*4 +: 4] = b.requests[v];
        return r;
    endfunction

    function automatic logic [7:0] port_flat();
        logic [7:0] p;
        for (int v = 0; v < NV; v++) p[v*2 +: 2] = b.vc_out_port[v];
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b.head_valid   = '0;
        b.flit_sent    = '0;
        b.flit_is_tail = '0;
        for (int v = 0; v < NV; v++) begin
            b.head_route[v] = '0;
            b.grants[v]     = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_flat() !== 16'h0) begin
            failures++;
            $display("FAIL reset_requests got %h exp 0000", req_flat());
        end
        checks++;
        if ({b.vc_active, b.starve, b.proto_err} !== 9'h0) begin
            failures++;
            $display("FAIL reset_status got act=%b st=%b err=%b exp 0",
                     b.vc_active, b.starve, b.proto_err);
        end
        checks++;
        if (port_flat() !== 8'h0) begin
            failures++;
            $display("FAIL reset_ports got %h exp 00", port_flat());
        end
    endtask

    task automatic test_basic();
        do_reset();
        b.head_valid[0] = 1'b1;
        b.head_route[0] = 2'd2;
        step();
        b.head_valid[0] = 1'b0;
        checks++;
        if (b.requests[0] !== 4'b0100 || b.vc_active !== 4'b0000) begin
            failures++;
            $display("FAIL basic_req got %b act=%b exp 0100 act=0000",
                     b.requests[0], b.vc_active);
        end
        step();
        step();
        b.grants[0] = 4'b0100;
        step();
        b.grants[0] = 4'b0000;
        checks++;
        if (b.vc_active !== 4'b0001 || b.requests[0] !== 4'b0000) begin
            failures++;
            $display("FAIL basic_grant got act=%b req=%b exp 0001 0000",
                     b.vc_active, b.requests[0]);
        end
        b.flit_sent[0] = 1'b1;
        repeat (3) step();
        checks++;
        if (b.vc_active !== 4'b0001) begin
            failures++;
            $display("FAIL basic_body got act=%b exp 0001", b.vc_active);
        end
        b.flit_is_tail[0] = 1'b1;
        step();
        clear_inputs();
        checks++;
        if (b.vc_active !== 4'b0000 || b.proto_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_tail got act=%b err=%b exp 0000 0",
                     b.vc_active, b.proto_err);
        end
    endtask

    task automatic test_starve();
        do_reset();
        b.head_valid[1] = 1'b1;
        b.head_route[1] = 2'd0;
        step();
        b.head_valid[1] = 1'b0;
        repeat (14) step();
        checks++;
        if (b.starve !== 4'b0000) begin
            failures++;
            $display("FAIL starve_early got %b exp 0000", b.starve);
        end
        step();
        checks++;
        if (b.starve !== 4'b0010 || b.requests[1] !== 4'b0001) begin
            failures++;
            $display("FAIL starve_rise got %b req=%b exp 0010 0001",
                     b.starve, b.requests[1]);
        end
        repeat (3) step();
        checks++;
        if (b.starve !== 4'b0010) begin
            failures++;
            $display("FAIL starve_hold got %b exp 0010", b.starve);
        end
        b.grants[1] = 4'b0001;
        step();
        b.grants[1] = 4'b0000;
        checks++;
        if (b.starve !== 4'b0000 || b.vc_active !== 4'b0010) begin
            failures++;
            $display("FAIL starve_grant got st=%b act=%b exp 0000 0010",
                     b.starve, b.vc_active);
        end
        b.flit_sent[1]    = 1'b1;
        b.flit_is_tail[1] = 1'b1;
        step();
        clear_inputs();
        checks++;
        if (b.vc_active !== 4'b0000 || b.proto_err !== 1'b0) begin
            failures++;
            $display("FAIL starve_release got act=%b err=%b exp 0000 0",
                     b.vc_active, b.proto_err);
        end
    endtask

    task automatic test_parallel();
        do_reset();
        b.head_valid = 4'b1111;
        for (int v = 0; v < NV; v++) b.head_route[v] = 2'(3 - v);
        step();
        b.head_valid = 4'b0000;
        checks++;
        if (req_flat() !== 16'h1248) begin
            failures++;
            $display("FAIL par_req got %h exp 1248", req_flat());
        end
        b.grants[0] = 4'b1000;
        b.grants[1] = 4'b0100;
        b.grants[2] = 4'b0010;
        b.grants[3] = 4'b0001;
        step();
        clear_inputs();
        checks++;
        if (b.vc_active !== 4'b1111 || req_flat() !== 16'h0) begin
            failures++;
            $display("FAIL par_active got act=%b req=%h exp 1111 0000",
                     b.vc_active, req_flat());
        end
        checks++;
        if (port_flat() !== 8'h1B || b.proto_err !== 1'b0) begin
            failures++;
            $display("FAIL par_ports got %h err=%b exp 1b 0",
                     port_flat(), b.proto_err);
        end
        b.flit_sent    = 4'b1111;
        b.flit_is_tail = 4'b1111;
        step();
        clear_inputs();
        checks++;
        if (b.vc_active !== 4'b0000) begin
            failures++;
            $display("FAIL par_release got %b exp 0000", b.vc_active);
        end
    endtask

    task automatic test_collision();
        do_reset();
        b.head_valid[2] = 1'b1;
        b.head_route[2] = 2'd3;
        step();
        b.head_valid[2] = 1'b0;
        b.grants[2] = 4'b1000;
        step();
        b.grants[2] = 4'b0000;
        checks++;
        if (b.vc_active !== 4'b0100) begin
            failures++;
            $display("FAIL coll_active got %b exp 0100", b.vc_active);
        end
        b.flit_sent[2]    = 1'b1;
        b.flit_is_tail[2] = 1'b1;
        b.head_valid[2]   = 1'b1;
        b.head_route[2]   = 2'd1;
        step();
        b.flit_sent[2]    = 1'b0;
        b.flit_is_tail[2] = 1'b0;
        checks++;
        if (b.vc_active !== 4'b0000 || b.requests[2] !== 4'b0000) begin
            failures++;
            $display("FAIL coll_bubble got act=%b req=%b exp 0000 0000",
                     b.vc_active, b.requests[2]);
        end
        step();
        b.head_valid[2] = 1'b0;
        checks++;
        if (b.requests[2] !== 4'b0010 || b.proto_err !== 1'b0) begin
            failures++;
            $display("FAIL coll_req got %b err=%b exp 0010 0",
                     b.requests[2], b.proto_err);
        end
    endtask

    task automatic test_err_idle_grant();
        do_reset();
        b.grants[3] = 4'b0001;
        step();
        b.grants[3] = 4'b0000;
        checks++;
        if (b.proto_err !== 1'b1 || b.vc_active !== 4'b0000 ||
            b.requests[3] !== 4'b0000) begin
            failures++;
            $display("FAIL err_idle got err=%b act=%b req=%b exp 1 0000 0000",
                     b.proto_err, b.vc_active, b.requests[3]);
        end
        repeat (2) step();
        checks++;
        if (b.proto_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %b exp 1", b.proto_err);
        end
    endtask

    task automatic test_err_wrong_grant();
        do_reset();
        b.head_valid[0] = 1'b1;
        b.head_route[0] = 2'd2;
        step();
        b.head_valid[0] = 1'b0;
        checks++;
        if (b.proto_err !== 1'b0) begin
            failures++;
            $display("FAIL err_wrong_pre got %b exp 0", b.proto_err);
        end
        b.grants[0] = 4'b0010;
        step();
        b.grants[0] = 4'b0000;
        checks++;
        if (b.proto_err !== 1'b1 || b.requests[0] !== 4'b0100 ||
            b.vc_active !== 4'b0000) begin
            failures++;
            $display("FAIL err_wrong got err=%b req=%b act=%b exp 1 0100 0000",
                     b.proto_err, b.requests[0], b.vc_active);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b.head_valid[0] = 1'b1;
        b.head_route[0] = 2'd1;
        b.head_valid[1] = 1'b1;
        b.head_route[1] = 2'd3;
        step();
        b.head_valid = 4'b0000;
        b.grants[0]  = 4'b0010;
        step();
        b.grants[0]    = 4'b0000;
        b.flit_sent[2] = 1'b1;
        step();
        b.flit_sent[2] = 1'b0;
        repeat (15) step();
        checks++;
        if (b.vc_active !== 4'b0001 || b.starve !== 4'b0010 ||
            b.proto_err !== 1'b1 || b.requests[1] !== 4'b1000) begin
            failures++;
            $display("FAIL mid_setup got act=%b st=%b err=%b req1=%b",
                     b.vc_active, b.starve, b.proto_err, b.requests[1]);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (req_flat() !== 16'h0 || b.vc_active !== 4'b0000 ||
            b.starve !== 4'b0000 || b.proto_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got req=%h act=%b st=%b err=%b exp 0",
                     req_flat(), b.vc_active, b.starve, b.proto_err);
        end
        step();
        checks++;
        if (req_flat() !== 16'h0 || b.vc_active !== 4'b0000) begin
            failures++;
            $display("FAIL mid_idle got req=%h act=%b exp 0000 0000",
                     req_flat(), b.vc_active);
        end
        b.grants[1] = 4'b1000;
        step();
        b.grants[1] = 4'b0000;
        checks++;
        if (b.proto_err !== 1'b1 || b.vc_active !== 4'b0000) begin
            failures++;
            $display("FAIL mid_vc1_idle got err=%b act=%b exp 1 0000",
                     b.proto_err, b.vc_active);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_starve();
        test_parallel();
        test_collision();
        test_err_idle_grant();
        test_err_wrong_grant();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vc_alloc_requester.md
Name: vc_alloc_requester

Overview:
- Requestor-side front end for the router's VC/switch allocator, one instance per input port.
- Tracks a per-VC state machine: it converts head-flit route information into registered one-hot request vectors in the allocator's requests/grants array format, and consumes grants.
- It holds the won output for the VC until the tail flit departs, then releases it.
- It also reports starvation and protocol errors for debug and verification.

Parameters:
- NUM_VCS, 4, number of virtual channels (requestors) on this input port.
- NUM_OUTS, 4, number of output resources; equals the allocator's NUM_RESS.
- MAX_WAIT, 15, request-age threshold in cycles at which starve is raised; must be >= 1.
- WAIT_W, $clog2(MAX_WAIT+1), width of the per-VC wait counter (derived).

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous active-low reset (0 = reset).
- head_valid, input, [NUM_VCS-1:0], VC buffer front holds a head flit.
- head_route, input, [$clog2(NUM_OUTS)-1:0] x NUM_VCS (unpacked), output port requested by each head flit.
- flit_sent, input, [NUM_VCS-1:0], one flit of VC v leaves the switch this cycle.
- flit_is_tail, input, [NUM_VCS-1:0], the flit leaving for VC v is a tail; qualified by flit_sent.
- requests, output, [NUM_OUTS-1:0] x NUM_VCS (unpacked), one-hot request per VC; connects to the allocator's requests.
- grants, input, [NUM_OUTS-1:0] x NUM_VCS (unpacked), grant vector from the allocator.
- vc_active, output, [NUM_VCS-1:0], VC holds an allocated output.
- vc_out_port, output, [$clog2(NUM_OUTS)-1:0] x NUM_VCS, latched route of each VC; valid when the VC is in REQ or ACTIVE.
- starve, output, [NUM_VCS-1:0], VC has waited >= MAX_WAIT cycles in REQ.
- proto_err, output, 1, sticky error flag.

Behaviour:
- Reset (reset==0 at posedge):
  - All VCs go to IDLE.
  - requests, vc_active, vc_out_port, starve, wait counters and proto_err clear to 0.
  - Reset asserted mid-operation drops any pending request and any held allocation the next cycle; no tail is required.
- Per-VC FSM, states IDLE, REQ and ACTIVE, all registered:
  - IDLE: if head_valid[v], latch head_route[v] into vc_out_port[v], clear wait[v], and go to REQ.
  - REQ: requests[v] = one-hot(vc_out_port[v]); other VCs' vectors are unaffected.
    - If grants[v][vc_out_port[v]]==1, go to ACTIVE.
    - Otherwise stay in REQ and wait[v] increments, saturating at MAX_WAIT.
    - head_route changes while in REQ are ignored (route is latched).
  - ACTIVE: vc_active[v]=1 and requests[v]=0.
    - flit_sent[v] & flit_is_tail[v] returns the VC to IDLE.
    - flit_sent[v] without tail stays in ACTIVE.
- Outputs:
  - requests and vc_active are functions of registered state only; there is no combinational path from any input.
  - starve[v] = (state==REQ) && (wait[v]==MAX_WAIT); it clears on leaving REQ.
- Latency:
  - head_valid sampled at edge t puts the request on the wire from t+1.
  - A grant sampled at edge t+k gives vc_active=1 from t+k+1; the request drops in the same cycle.
  - Minimum head-to-active latency is 2 cycles.
- Simultaneous events:
  - Tail sent and head_valid in the same cycle while ACTIVE: the VC goes to IDLE, and the new head is latched on the following edge (one-cycle bubble, mandatory).
  - Grants to several VCs in one cycle are processed independently.
- Errors (proto_err set sticky until reset):
  - Any grants[v] bit set while VC v is not in REQ.
  - Any grants[v] bit set other than the requested bit.
  - flit_sent[v] while VC v is not ACTIVE.
  - Erroneous grants never change state.

Test Plan:
1. Basic flow. VC0 head_valid=1, route=2 at edge 0 -> requests[0]=4'b0100 from cycle 1. Grant 4'b0100 at edge 3 -> vc_active[0]=1 from cycle 4, requests[0]=0. Three body flits plus one tail sent -> vc_active[0]=0 the cycle after the tail.
2. Starvation. VC1 requesting route 0 with grants withheld, MAX_WAIT=15 -> starve[1]=1 exactly 15 cycles after entering REQ and held high. Grant then arrives -> starve[1]=0 and vc_active[1]=1 the next cycle.
3. Parallel VCs. VCs 0–3 request routes 3,2,1,0 together; all four grants arrive in one cycle -> vc_active=4'b1111 the next cycle, vc_out_port={0,1,2,3}, proto_err=0.
4. Tail/head collision. VC2 ACTIVE; tail sent with head_valid=1, route=1 in the same cycle -> IDLE for one cycle, then REQ with requests[2]=4'b0010.
5. Errors:
   - Grant 4'b0001 to VC3 while it is IDLE -> proto_err=1, VC3 stays IDLE.
   - Separate run: VC0 requesting 4'b0100 receives grant 4'b0010 -> proto_err=1, VC0 stays in REQ.
6. Reset mid-operation. VC0 ACTIVE and VC1 in REQ, reset=0 for one cycle -> requests, vc_active, starve and proto_err all 0 the next cycle, and both VCs are in IDLE.
